mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage controller directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM outputs (ALU result, store data, Rd, control bits) and performs the data-memory access over a req/ack handshake to a multi-cycle data memory.
- Stalls the upstream pipeline while the access is outstanding, then loads the MEM/WB register that feeds write-back.

Parameters:
TIMEOUT, 255, max ACCESS cycles waiting for mem_ack_i before abort (1..255; 8-bit counter)

Ports:
clk_i  in  1  clock, posedge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  global enable; low = no new access accepted, MEM/WB holds
ALU_Result_i  in  32  from EX/MEM; memory address or ALU result
MemWrite_Data_i  in  32  from EX/MEM; store data
Rd_Addr_i  in  5  from EX/MEM; destination register
RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i  in  1 each  from EX/MEM control
mem_req_o  out  1  memory request, held until ack
mem_we_o  out  1  1 = write
mem_addr_o  out  32  word address (bits [1:0] always 0)
mem_wdata_o  out  32  store data
mem_ack_i  in  1  memory completion, single-cycle pulse
mem_rdata_i  in  32  read data, valid when mem_ack_i=1
stall_o  out  1  hold EX/MEM and all earlier stages
ALU_Result_o, Mem_Data_o  out  32 each  to MEM/WB consumers
Rd_Addr_o  out  5  to MEM/WB consumers
RegWrite_o, MemToReg_o  out  1 each  to MEM/WB consumers
err_timeout_o, err_misalign_o  out  1 each  sticky error flags

Behaviour:
- Reset (rst_i=0, async): state=IDLE; access counter=0; every output 0 immediately, including mem_req_o mid-access. Captured access is discarded.
- memop = start_i & (MemRead_i | MemWrite_i). If both read and write are set, the access is a write.
- States: IDLE, ACCESS, DONE (Moore for mem_* outputs).
- IDLE, start_i=0: state and MEM/WB outputs hold; stall_o=0.
- IDLE, non-memop with start_i=1: next edge loads MEM/WB: ALU_Result_o=ALU_Result_i, Rd_Addr_o, RegWrite_o, MemToReg_o from inputs, Mem_Data_o=0. Latency 1, no stall.
- IDLE, memop with ALU_Result_i[1:0]!=0 (misaligned): no request. err_misalign_o<=1. MEM/WB loads the instruction with RegWrite_o=0. No stall.
- IDLE, aligned memop: stall_o=1 combinationally. Next edge captures address, store data, we, Rd and control into hold registers; MEM/WB loads a bubble (RegWrite_o=0, MemToReg_o=0); counter<=0; go to ACCESS.
- ACCESS:
  - mem_req_o=1; mem_addr_o, mem_we_o and mem_wdata_o come from the hold registers and stay stable.
  - stall_o=1; MEM/WB holds the bubble; counter increments each cycle.
  - mem_ack_i=1: capture mem_rdata_i (reads only; 0 for writes) and go to DONE.
  - No ack by the cycle where counter==TIMEOUT-1: go to DONE with err_timeout_o<=1, Mem_Data=0, RegWrite suppressed.
  - If ack arrives on the final allowed cycle, ack wins and there is no error.
  - start_i is ignored in ACCESS.
- DONE (exactly 1 cycle):
  - mem_req_o=0, stall_o=0; EX/MEM inputs are ignored (they still show the same instruction).
  - Next edge loads MEM/WB with the held instruction: ALU_Result_o=held address, Mem_Data_o=captured data, Rd_Addr_o, RegWrite_o, MemToReg_o from the held control (RegWrite_o forced 0 on timeout).
  - Returns to IDLE.
- mem_ack_i outside ACCESS is ignored.
- Error flags are sticky until reset.
- Stores always produce RegWrite_o as held (normally 0).
- Total aligned access: stall_o high for 1 + N cycles, where N = ACCESS cycles to ack; result appears in MEM/WB N+2 edges after the instruction is first presented.

Test Plan:
- Reset: drive rst_i=0 during ACCESS -> mem_req_o, stall_o and all outputs 0 without a clock edge; after release, state is IDLE and err flags are 0.
- ALU pass-through: RegWrite_i=1, ALU_Result_i=0x00000010, Rd_Addr_i=5 -> next edge ALU_Result_o=0x10, Rd_Addr_o=5, RegWrite_o=1; stall_o never 1.
- Load, ack on 3rd ACCESS cycle: addr 0x100, mem_rdata_i=0xDEADBEEF -> mem_req_o high 3 cycles with mem_addr_o=0x100 and mem_we_o=0; stall_o high 4 cycles; Mem_Data_o=0xDEADBEEF, MemToReg_o=1, RegWrite_o=1 after the DONE edge.
- Store, immediate ack: addr 0x204, data 0x12345678, ack on 1st ACCESS cycle -> mem_we_o=1, mem_wdata_o=0x12345678; stall_o high 2 cycles; RegWrite_o=0.
- Timeout with TIMEOUT=4, no ack -> mem_req_o high exactly 4 cycles then drops; err_timeout_o=1; instruction retires with RegWrite_o=0; the next ALU op proceeds normally.
- Misaligned load at addr 0x102 -> mem_req_o stays 0, err_misalign_o=1, RegWrite_o=0 on the next edge, stall_o stays 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM-stage controller: takes the EX/MEM outputs, runs the data-memory
// req/ack access, stalls upstream while it is outstanding, then loads MEM/WB.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no access pending; ALU ops and misaligned ops retire in 1 edge
// ACCESS | request held to memory; waiting for ack or timeout
// DONE   | one cycle; retires the held instruction into MEM/WB
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] ALU_Result_i,
  input  logic [31:0] MemWrite_Data_i,
  input  logic [4:0]  Rd_Addr_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] ALU_Result_o,
  output logic [31:0] Mem_Data_o,
  output logic [4:0]  Rd_Addr_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic        err_timeout_o,
  output logic        err_misalign_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        memop, aligned, issue;
  logic        ack_hit, timeout_hit;

  logic [31:0] hold_addr, hold_wdata, hold_rdata;
  logic [4:0]  hold_rd;
  logic        hold_we, hold_rw, hold_m2r, hold_to;

  assign memop       = start_i & (MemRead_i | MemWrite_i);
  assign aligned     = (ALU_Result_i[1:0] == 2'b00);
  assign issue       = (state == IDLE) & memop & aligned;
  assign ack_hit     = (state == ACCESS) & mem_ack_i;
  // ack on the last allowed cycle takes priority over the timeout
  assign timeout_hit = (state == ACCESS) & ~mem_ack_i & (cnt == CNT_LAST);

  // Moore memory interface; quiet outside ACCESS
  assign mem_req_o   = (state == ACCESS);
  assign mem_we_o    = mem_req_o & hold_we;
  assign mem_addr_o  = mem_req_o ? hold_addr : 32'h0;
  assign mem_wdata_o = mem_req_o ? hold_wdata : 32'h0;

  // stall is forced low during reset so every output drops immediately
  assign stall_o = rst_i & ((state == ACCESS) | issue);

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = ACCESS;
      ACCESS:  if (ack_hit || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // access-cycle counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                 cnt <= 8'd0;
    else if (issue)             cnt <= 8'd0;
    else if (state == ACCESS)   cnt <= cnt + 8'd1;
  end

  // hold registers for the outstanding access and its outcome
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hold_addr  <= 32'h0;
      hold_wdata <= 32'h0;
      hold_rdata <= 32'h0;
      hold_rd    <= 5'd0;
      hold_we    <= 1'b0;
      hold_rw    <= 1'b0;
      hold_m2r   <= 1'b0;
      hold_to    <= 1'b0;
    end else if (issue) begin
      hold_addr  <= {ALU_Result_i[31:2], 2'b00};
      hold_wdata <= MemWrite_Data_i;
      hold_rdata <= 32'h0;
      hold_rd    <= Rd_Addr_i;
      hold_we    <= MemWrite_i;
      hold_rw    <= RegWrite_i;
      hold_m2r   <= MemToReg_i;
      hold_to    <= 1'b0;
    end else if (ack_hit) begin
      hold_rdata <= hold_we ? 32'h0 : mem_rdata_i;
    end else if (timeout_hit) begin
      hold_rdata <= 32'h0;
      hold_to    <= 1'b1;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ALU_Result_o <= 32'h0;
      Mem_Data_o   <= 32'h0;
      Rd_Addr_o    <= 5'd0;
      RegWrite_o   <= 1'b0;
      MemToReg_o   <= 1'b0;
    end else if (state == DONE) begin
      ALU_Result_o <= hold_addr;
      Mem_Data_o   <= hold_rdata;
      Rd_Addr_o    <= hold_rd;
      RegWrite_o   <= hold_rw & ~hold_to;
      MemToReg_o   <= hold_m2r;
    end else if (state == IDLE && start_i) begin
      if (issue) begin
        RegWrite_o <= 1'b0;
        MemToReg_o <= 1'b0;
      end else begin
        // plain ALU op, or a misaligned memop retired without a write-back
        ALU_Result_o <= ALU_Result_i;
        Mem_Data_o   <= 32'h0;
        Rd_Addr_o    <= Rd_Addr_i;
        RegWrite_o   <= RegWrite_i & ~memop;
        MemToReg_o   <= MemToReg_i;
      end
    end
  end

  // sticky error flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_timeout_o  <= 1'b0;
      err_misalign_o <= 1'b0;
    end else begin
      if (timeout_hit)                        err_timeout_o  <= 1'b1;
      if (state == IDLE && memop && !aligned) err_misalign_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a small scoreboard of expected
// MEM/WB results.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] alu_in = '0, wdata_in = '0, rdata = '0;
  logic [4:0]  rd_in = '0;
  logic        rw_in = 0, m2r_in = 0, mr_in = 0, mw_in = 0, ack = 0;
  logic        req, we, stall, rw_out, m2r_out, err_to, err_mis;
  logic [31:0] addr, wdata, alu_out, mdata;
  logic [4:0]  rd_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t exp_q[$];

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .ALU_Result_i(alu_in), .MemWrite_Data_i(wdata_in), .Rd_Addr_i(rd_in),
    .RegWrite_i(rw_in), .MemToReg_i(m2r_in), .MemRead_i(mr_in), .MemWrite_i(mw_in),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
    .mem_ack_i(ack), .mem_rdata_i(rdata), .stall_o(stall),
    .ALU_Result_o(alu_out), .Mem_Data_o(mdata), .Rd_Addr_o(rd_out),
    .RegWrite_o(rw_out), .MemToReg_o(m2r_out),
    .err_timeout_o(err_to), .err_misalign_o(err_mis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Presents one instruction, plays the memory side, and checks the retire.
  task automatic run_instr(input string tag, input logic [31:0] a, input logic [31:0] wd,
                           input logic [4:0] rd, input logic rw, input logic m2r,
                           input logic mr, input logic mw, input int ack_at,
                           input logic [31:0] rd_data);
    exp_t e;
    int   n_stall, n_req, cyc;
    logic is_mem, alig;
    is_mem = mr | mw;
    alig   = (a[1:0] == 2'b00);
    e.alu = a; e.rd = rd; e.rw = rw; e.m2r = m2r; e.data = '0; e.stalls = 0; e.reqs = 0;
    if (is_mem && !alig) e.rw = 1'b0;
    else if (is_mem) begin
      if (ack_at >= 1 && ack_at <= TO) begin
        e.reqs = ack_at;
        if (!mw) e.data = rd_data;
      end else begin
        e.reqs = TO;
        e.rw   = 1'b0;
      end
      e.stalls = e.reqs + 1;
    end
    exp_q.push_back(e);

    @(negedge clk);
    alu_in = a; wdata_in = wd; rd_in = rd; rw_in = rw; m2r_in = m2r;
    mr_in = mr; mw_in = mw; start = 1'b1; ack = 1'b0;
    n_stall = 0; n_req = 0; cyc = 0;
    while (1) begin
      #1;
      if (req) begin
        n_req++;
        chk({tag, "_addr"}, addr, {a[31:2], 2'b00});
        chk({tag, "_we"}, 32'(we), 32'(mw));
        if (mw) chk({tag, "_wdata"}, wdata, wd);
        ack   = (n_req == ack_at);
        rdata = ack ? rd_data : 32'hBAD0BAD0;
      end else begin
        ack   = 1'b0;
        rdata = 32'h5A5A5A5A;
      end
      if (stall) n_stall++;
      if (!stall) break;
      cyc++;
      if (cyc > 40) begin
        chk({tag, "_cycle_bound"}, 32'(cyc), 32'd40);
        break;
      end
      @(posedge clk);
      if (cyc == 1 && is_mem && alig) begin
        #1;
        chk({tag, "_bubble_rw"}, 32'(rw_out), 32'd0);
        chk({tag, "_bubble_m2r"}, 32'(m2r_out), 32'd0);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    start = 1'b0; ack = 1'b0;
    e = exp_q.pop_front();
    chk({tag, "_alu"}, alu_out, e.alu);
    chk({tag, "_mdata"}, mdata, e.data);
    chk({tag, "_rd"}, 32'(rd_out), 32'(e.rd));
    chk({tag, "_rw"}, 32'(rw_out), 32'(e.rw));
    chk({tag, "_m2r"}, 32'(m2r_out), 32'(e.m2r));
    chk({tag, "_stalls"}, 32'(n_stall), 32'(e.stalls));
    chk({tag, "_reqs"}, 32'(n_req), 32'(e.reqs));
  endtask

  initial begin
    #3;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_alu", alu_out, 32'd0);
    chk("rst_errs", {30'd0, err_to, err_mis}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("alu_pass", 32'h10, 32'h0, 5'd5, 1, 0, 0, 0, 0, 32'h0);
    run_instr("load_ack3", 32'h100, 32'h0, 5'd7, 1, 1, 1, 0, 3, 32'hDEADBEEF);
    run_instr("store_ack1", 32'h204, 32'h12345678, 5'd2, 0, 0, 0, 1, 1, 32'h0);
    run_instr("load_ack_last", 32'h300, 32'h0, 5'd8, 1, 1, 1, 0, TO, 32'hCAFEF00D);
    chk("no_timeout_err", 32'(err_to), 32'd0);
    run_instr("load_timeout", 32'h400, 32'h0, 5'd9, 1, 1, 1, 0, 0, 32'h0);
    chk("timeout_err", 32'(err_to), 32'd1);
    run_instr("alu_after_to", 32'hABC, 32'h0, 5'd3, 1, 0, 0, 0, 0, 32'h0);
    run_instr("rw_store", 32'h508, 32'hFEEDFACE, 5'd4, 0, 0, 1, 1, 2, 32'h11111111);
    chk("misalign_err_pre", 32'(err_mis), 32'd0);
    run_instr("misalign", 32'h102, 32'h0, 5'd6, 1, 1, 1, 0, 0, 32'h0);
    chk("misalign_err", 32'(err_mis), 32'd1);
    chk("timeout_sticky", 32'(err_to), 32'd1);

    // start low: nothing accepted, MEM/WB holds, stray ack ignored
    @(negedge clk);
    alu_in = 32'h700; rd_in = 5'd1; rw_in = 1; mr_in = 1; mw_in = 0; start = 1'b0;
    ack = 1'b1; rdata = 32'h99999999;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_alu", alu_out, 32'h102);
    chk("hold_mdata", mdata, 32'h0);
    chk("hold_req", 32'(req), 32'd0);
    chk("hold_stall", 32'(stall), 32'd0);
    ack = 1'b0;

    // asynchronous reset in the middle of an access
    @(negedge clk);
    alu_in = 32'h600; start = 1'b1;
    @(posedge clk);
    #2;
    chk("pre_rst_req", 32'(req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_req", 32'(req), 32'd0);
    chk("async_stall", 32'(stall), 32'd0);
    chk("async_addr", addr, 32'd0);
    chk("async_alu", alu_out, 32'd0);
    chk("async_rd", 32'(rd_out), 32'd0);
    chk("async_errs", {30'd0, err_to, err_mis}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_req", 32'(req), 32'd0);
    chk("post_rst_errs", {30'd0, err_to, err_mis}, 32'd0);
    run_instr("alu_post_rst", 32'h44, 32'h0, 5'd10, 1, 0, 0, 0, 0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
